// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a registered one-hot grant.
// A grant is held until the owner signals done, withdraws its request, or
// reaches the hold limit. The requester after the released owner gets top priority.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned TIMER_W  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       active,
    output logic       any_req,
    output logic       timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    // Last timer value of a grant. With the limit disabled the timer just
    // saturates at all-ones and never forces a release.
    localparam logic [TIMER_W-1:0] HoldLast =
        (MAX_HOLD == 0) ? {TIMER_W{1'b1}} : TIMER_W'(MAX_HOLD - 1);
    localparam bit LimitEn = (MAX_HOLD != 0);

    state_e             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [7:0]         gnt_q, gnt_d;
    logic [2:0]         gnt_id_q, gnt_id_d;
    logic               timeout_q, timeout_d;

    logic [2:0]         sel;
    logic               sel_vld;
    logic               rel;

    // Any-request detect, independent of state and reset.
    assign any_req = |req;

    // Pick the first set request scanning upward from ptr, wrapping 7 -> 0.
    always_comb begin
        sel     = 3'd0;
        sel_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            idx = ptr_q + 3'(i);
            if (!sel_vld && req[idx]) begin
                sel     = idx;
                sel_vld = 1'b1;
            end
        end
    end

    // Next-state: grant on request in idle, release on done/withdraw/limit.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        timeout_d = 1'b0;
        rel       = 1'b0;

        unique case (state_q)
            StIdle: begin
                // done is deliberately ignored here.
                if (any_req && sel_vld) begin
                    state_d  = StGrant;
                    gnt_d    = 8'b1 << sel;
                    gnt_id_d = sel;
                    timer_d  = '0;
                end
            end
            StGrant: begin
                // done wins over the limit, so a done on the last cycle is a
                // normal release without a timeout pulse.
                if (done || !req[gnt_id_q]) begin
                    rel = 1'b1;
                end else if (LimitEn && (timer_q == HoldLast)) begin
                    rel       = 1'b1;
                    timeout_d = 1'b1;
                end else if (timer_q != HoldLast) begin
                    timer_d = timer_q + 1'b1;
                end

                if (rel) begin
                    state_d  = StIdle;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    timer_d  = '0;
                    // Owner drops to lowest priority.
                    ptr_d    = gnt_id_q + 3'd1;
                end
            end
            default: begin
                state_d  = StIdle;
                gnt_d    = '0;
                gnt_id_d = '0;
                timer_d  = '0;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= 3'd0;
            timer_q   <= '0;
            gnt_q     <= 8'd0;
            gnt_id_q  <= 3'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign active  = (state_q == StGrant);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios plus randomized
// traffic, compared every cycle against a behavioural model.
module tb_rr_arbiter_8;

    localparam int MaxHold = 4;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       active;
    logic       any_req;
    logic       timeout;

    rr_arbiter_8 #(
        .MAX_HOLD(MaxHold),
        .TIMER_W (3)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .active (active),
        .any_req(any_req),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Model state: owner index (-1 = none), priority start, cycles the
    // current grant has been visible, and the forced-release flag.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    int grants[$];
    int cnt_gnt;
    int cnt_to;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_step(input logic [7:0] r, input logic d, input logic rs);
        if (rs) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_to    = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            if (r != 8'd0) begin
                bit found = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    int c = (m_ptr + k) % 8;
                    if (!found && r[c]) begin
                        m_owner = c;
                        found   = 1'b1;
                    end
                end
                m_held = 1;
            end
        end else begin
            m_to = 1'b0;
            if (d || !r[m_owner]) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else if (MaxHold != 0 && m_held == MaxHold) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
        end
    endfunction

    // One clock: drive inputs while clk is low, step model at the edge, compare #1 later.
    task automatic tick(input logic [7:0] r, input logic d, input logic rs);
        logic [7:0] exp_gnt;
        req   = r;
        done  = d;
        reset = rs;
        #1;
        check("any_req", 32'(any_req), 32'(|r));
        @(posedge clk);
        model_step(r, d, rs);
        #1;
        exp_gnt = (m_owner < 0) ? 8'd0 : (8'd1 << m_owner);
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("gnt_id", 32'(gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("active", 32'(active), 32'(m_owner >= 0));
        check("timeout", 32'(timeout), 32'(m_to));
        check("onehot", 32'($onehot0(gnt)), 32'd1);
        if (m_owner >= 0 && m_held == 1) grants.push_back(int'(gnt_id));
        if (gnt == 8'h08) cnt_gnt++;
        if (timeout) cnt_to++;
        @(negedge clk);
    endtask

    initial begin
        req   = 8'd0;
        done  = 1'b0;
        reset = 1'b1;

        // Reset, then idle with no requests.
        tick(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(8'h00, 1'b0, 1'b0);

        // Single request from g, then done -> ptr moves to 7.
        tick(8'h40, 1'b0, 1'b0);
        check("g_grant", 32'(gnt), 32'h40);
        tick(8'h40, 1'b1, 1'b0);
        check("g_release", 32'(gnt), 32'h00);

        // From ptr=7, a and g alternate across the 7->0 wrap.
        grants.delete();
        for (int i = 0; i < 8; i++) tick(8'h41, (m_owner >= 0), 1'b0);
        check("wrap_cnt", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check("wrap_seq", 32'(grants[i]), (i % 2 == 0) ? 32'd0 : 32'd6);

        // All requesting, done on 2nd grant cycle: full rotation.
        tick(8'hFF, 1'b0, 1'b1);
        grants.delete();
        for (int i = 0; i < 27; i++) tick(8'hFF, (m_owner >= 0 && m_held == 2), 1'b0);
        check("rot_cnt", 32'(grants.size()), 32'd9);
        for (int i = 0; i < 9 && i < grants.size(); i++)
            check("rot_seq", 32'(grants[i]), 32'(i % 8));

        // Hold limit: forced release after 4 cycles, then done on the 4th cycle.
        tick(8'h08, 1'b0, 1'b1);
        cnt_gnt = 0;
        cnt_to  = 0;
        for (int i = 0; i < 6; i++) tick(8'h08, 1'b0, 1'b0);
        check("limit_gnt", 32'(cnt_gnt), 32'd5);
        check("limit_to", 32'(cnt_to), 32'd1);
        for (int i = 0; i < 4; i++) tick(8'h08, (m_owner >= 0 && m_held == MaxHold), 1'b0);
        check("done_at_limit_gnt", 32'(cnt_gnt), 32'd8);
        check("done_at_limit_to", 32'(cnt_to), 32'd1);

        // Reset mid-grant, then ptr is back to 0.
        tick(8'h04, 1'b0, 1'b1);
        tick(8'h04, 1'b0, 1'b0);
        check("c_grant", 32'(gnt), 32'h04);
        tick(8'h05, 1'b0, 1'b1);
        check("mid_reset", 32'({gnt, gnt_id, active, timeout}), 32'd0);
        tick(8'h05, 1'b0, 1'b0);
        check("post_reset", 32'(gnt), 32'h01);

        // Owner withdraws mid-grant.
        tick(8'h04, 1'b0, 1'b1);
        tick(8'h04, 1'b0, 1'b0);
        tick(8'h04, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0);
        check("withdraw", 32'({gnt, timeout}), 32'd0);

        // Randomized traffic with occasional resets.
        begin
            logic [7:0] r;
            r = 8'h00;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 3) == 0) r = 8'($urandom);
                tick(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
